// File: rtl/os_assembler.sv
// Assembles 16-symbol 128b/130b ordered-set blocks from one lane into 128-bit words.
// Optional: define OS_SKP_FILTER_EN to suppress delivery of SKP blocks (symbol 0 == 8'hAA).
module os_assembler #(
  parameter int SYMS_PER_BLOCK = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sym_in,
  input  logic             sym_valid,
  input  logic             block_start,
  input  logic [1:0]       sync_hdr,
  output logic [127:0]     orderedset,
  output logic             valid,
  output logic             block_err,
  output logic [CNT_W-1:0] os_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSEMBLE = 2'd1;
  localparam logic [1:0] DISCARD  = 2'd2;

  localparam logic [1:0] HDR_OS   = 2'b01;
  localparam logic [1:0] HDR_DATA = 2'b10;

  localparam logic [3:0] LAST_IDX = 4'(SYMS_PER_BLOCK - 1);

  logic [1:0]   state;
  logic [3:0]   sym_idx;
  logic [127:0] buffer;
  logic [127:0] full_block;
  logic         is_skp;
  logic         early_boundary;

  assign state_dbg  = state;
  // The symbol arriving now is slot 15; it is not in buffer yet, so splice it in.
  assign full_block = {sym_in, buffer[119:0]};
  assign early_boundary = (state != IDLE) && (sym_idx != 4'd0);

`ifdef OS_SKP_FILTER_EN
  assign is_skp = (buffer[7:0] == 8'hAA);
`else
  assign is_skp = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sym_idx    <= 4'd0;
      buffer     <= '0;
      orderedset <= '0;
      valid      <= 1'b0;
      block_err  <= 1'b0;
      os_count   <= '0;
    end else begin
      valid     <= 1'b0;
      block_err <= 1'b0;
      if (sym_valid) begin
        if (block_start) begin
          // An early boundary and a bad header in the same cycle still give one pulse.
          if (early_boundary) begin
            block_err <= 1'b1;
          end
          case (sync_hdr)
            HDR_OS: begin
              buffer[7:0] <= sym_in;
              sym_idx     <= 4'd1;
              state       <= ASSEMBLE;
            end
            HDR_DATA: begin
              sym_idx <= 4'd1;
              state   <= DISCARD;
            end
            default: begin
              block_err <= 1'b1;
              sym_idx   <= 4'd0;
              state     <= IDLE;
            end
          endcase
        end else begin
          case (state)
            ASSEMBLE: begin
              buffer[{sym_idx, 3'b000} +: 8] <= sym_in;
              if (sym_idx == LAST_IDX) begin
                sym_idx <= 4'd0;
                state   <= IDLE;
                if (!is_skp) begin
                  orderedset <= full_block;
                  valid      <= 1'b1;
                  if (os_count != '1) begin
                    os_count <= os_count + 1'b1;
                  end
                end
              end else begin
                sym_idx <= sym_idx + 4'd1;
              end
            end
            DISCARD: begin
              if (sym_idx == LAST_IDX) begin
                sym_idx <= 4'd0;
                state   <= IDLE;
              end else begin
                sym_idx <= sym_idx + 4'd1;
              end
            end
            default: begin
              sym_idx <= 4'd0;
              state   <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_os_assembler.sv
// Directed bench for os_assembler: block assembly, stalls, data skip, framing errors, reset, SKP, saturation.
module tb_os_assembler;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       sym_in;
  logic             sym_valid;
  logic             block_start;
  logic [1:0]       sync_hdr;
  logic [127:0]     orderedset;
  logic             valid;
  logic             block_err;
  logic [CNT_W-1:0] os_count;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;

  // Pulse counters maintained by the monitor below.
  int   valid_cnt  = 0;
  int   err_cnt    = 0;
  logic prev_valid = 1'b0;
  logic back2back  = 1'b0;

  logic [7:0]   blk [16];
  logic [127:0] exp_os;
  int           v0;
  int           e0;

  always #5 clk = ~clk;

  os_assembler #(.SYMS_PER_BLOCK(16), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .block_start (block_start),
    .sync_hdr    (sync_hdr),
    .orderedset  (orderedset),
    .valid       (valid),
    .block_err   (block_err),
    .os_count    (os_count),
    .state_dbg   (state_dbg)
  );

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (block_err) err_cnt++;
    if (valid && prev_valid) back2back = 1'b1;
    prev_valid = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic bs, input logic [1:0] h);
    @(negedge clk);
    sym_in      = s;
    sym_valid   = 1'b1;
    block_start = bs;
    sync_hdr    = h;
    @(posedge clk);
    #1;
    sym_valid   = 1'b0;
    block_start = 1'b0;
  endtask

  task automatic stall();
    @(negedge clk);
    sym_valid   = 1'b0;
    block_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) send(blk[i], (i == 0), h);
  endtask

  function automatic logic [127:0] pack_blk();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = blk[i];
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    sym_in      = 8'h00;
    sym_valid   = 1'b0;
    block_start = 1'b0;
    sync_hdr    = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_orderedset", orderedset, 128'h0);
    check("rst_valid", {127'h0, valid}, 128'h0);
    check("rst_block_err", {127'h0, block_err}, 128'h0);
    check("rst_os_count", {120'h0, os_count}, 128'h0);
    check("rst_state", {126'h0, state_dbg}, 128'h0);
    reset = 1'b1;

    // Contiguous block 00..0F
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    send_block(2'b01, 16);
    @(negedge clk);
    check("t1_valid", {127'h0, valid}, 128'h1);
    check("t1_os", orderedset, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_count", {120'h0, os_count}, 128'h1);
    @(negedge clk);
    check("t1_valid_drop", {127'h0, valid}, 128'h0);
    check("t1_os_hold", orderedset, 128'h0F0E0D0C0B0A09080706050403020100);

    // TS1 block with sym_valid toggling
    for (int i = 0; i < 16; i++) blk[i] = 8'h4A;
    blk[0] = 8'h1E; blk[1] = 8'h05; blk[2] = 8'hF7; blk[10] = 8'h2A;
    v0 = valid_cnt;
    for (int i = 0; i < 16; i++) begin
      send(blk[i], (i == 0), 2'b01);
      if (i != 15) stall();
    end
    @(negedge clk);
    check("t2_valid", {127'h0, valid}, 128'h1);
    check("t2_sym1", {120'h0, orderedset[15:8]}, 128'h05);
    check("t2_sym2", {120'h0, orderedset[23:16]}, 128'hF7);
    check("t2_sym10", {120'h0, orderedset[87:80]}, 128'h2A);
    check("t2_os", orderedset, 128'h4A4A4A4A4A2A4A4A4A4A4A4A4AF7051E);
    @(negedge clk);
    check("t2_one_valid", 128'(valid_cnt - v0), 128'h1);
    check("t2_count", {120'h0, os_count}, 128'h2);

    // Data block is dropped, following OS block delivered
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 16; i++) blk[i] = 8'hC0 + 8'(i);
    send_block(2'b10, 5);
    check("t3_discard_state", {126'h0, state_dbg}, 128'h2);
    for (int i = 5; i < 16; i++) send(blk[i], 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("t3_no_valid_data", 128'(valid_cnt - v0), 128'h0);
    for (int i = 0; i < 16; i++) blk[i] = 8'h30 + 8'(i);
    send_block(2'b01, 16);
    repeat (2) @(negedge clk);
    check("t3_one_valid_os", 128'(valid_cnt - v0), 128'h1);
    check("t3_os", orderedset, 128'h3F3E3D3C3B3A39383736353433323130);
    check("t3_no_err", 128'(err_cnt - e0), 128'h0);
    check("t3_count", {120'h0, os_count}, 128'h3);

    // Early boundary after 7 symbols
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 16; i++) blk[i] = 8'h50 + 8'(i);
    send_block(2'b01, 7);
    for (int i = 0; i < 16; i++) blk[i] = 8'h60 + 8'(i);
    send(blk[0], 1'b1, 2'b01);
    @(negedge clk);
    check("t4_err_pulse", {127'h0, block_err}, 128'h1);
    check("t4_no_valid", {127'h0, valid}, 128'h0);
    for (int i = 1; i < 16; i++) send(blk[i], 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("t4_one_valid", 128'(valid_cnt - v0), 128'h1);
    check("t4_os", orderedset, 128'h6F6E6D6C6B6A69686766656463626160);
    check("t4_one_err", 128'(err_cnt - e0), 128'h1);
    check("t4_count", {120'h0, os_count}, 128'h4);

    // Invalid header 11, then 15 plain symbols ignored
    v0 = valid_cnt; e0 = err_cnt;
    send(8'h77, 1'b1, 2'b11);
    @(negedge clk);
    check("t5_err_pulse", {127'h0, block_err}, 128'h1);
    for (int i = 1; i < 16; i++) send(8'(i), 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("t5_no_valid", 128'(valid_cnt - v0), 128'h0);
    check("t5_one_err", 128'(err_cnt - e0), 128'h1);
    check("t5_idle", {126'h0, state_dbg}, 128'h0);

    // Early boundary carrying an invalid header gives one pulse
    e0 = err_cnt;
    for (int i = 0; i < 16; i++) blk[i] = 8'h80 + 8'(i);
    send_block(2'b01, 3);
    send(8'h99, 1'b1, 2'b00);
    repeat (3) @(negedge clk);
    check("t5b_single_err", 128'(err_cnt - e0), 128'h1);
    check("t5b_no_valid", 128'(valid_cnt - v0), 128'h0);

    // Reset mid-ASSEMBLE
    send_block(2'b01, 5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_os", orderedset, 128'h0);
    check("t6_rst_count", {120'h0, os_count}, 128'h0);
    check("t6_rst_valid", {127'h0, valid}, 128'h0);
    check("t6_rst_state", {126'h0, state_dbg}, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 5; i < 16; i++) send(blk[i], 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("t6_no_valid_after", 128'(valid_cnt - v0), 128'h0);
    check("t6_no_err_after", 128'(err_cnt - e0), 128'h0);

    // SKP block followed by TS1 block
    pulse_reset();
    v0 = valid_cnt;
    for (int i = 0; i < 16; i++) blk[i] = 8'hAA;
    send_block(2'b01, 16);
    for (int i = 0; i < 16; i++) blk[i] = 8'h4A;
    blk[0] = 8'h1E; blk[1] = 8'h05; blk[2] = 8'hF7; blk[10] = 8'h2A;
    exp_os = pack_blk();
    send_block(2'b01, 16);
    repeat (2) @(negedge clk);
`ifdef OS_SKP_FILTER_EN
    check("t7_valids", 128'(valid_cnt - v0), 128'h1);
    check("t7_count", {120'h0, os_count}, 128'h1);
`else
    check("t7_valids", 128'(valid_cnt - v0), 128'h2);
    check("t7_count", {120'h0, os_count}, 128'h2);
`endif
    check("t7_os", orderedset, exp_os);

    // os_count saturation
    pulse_reset();
    for (int i = 0; i < 16; i++) blk[i] = 8'hD0 + 8'(i);
    for (int b = 0; b < 254; b++) send_block(2'b01, 16);
    repeat (2) @(negedge clk);
    check("t8_count_254", {120'h0, os_count}, 128'hFE);
    for (int b = 0; b < 3; b++) send_block(2'b01, 16);
    repeat (2) @(negedge clk);
    check("t8_count_sat", {120'h0, os_count}, 128'hFF);
    check("t8_os", orderedset, 128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0);

    check("no_back_to_back_valid", {127'h0, back2back}, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/os_assembler.md
Name: os_assembler

Overview:
Front end of the receive LTSSM path. Takes the descrambled, block-aligned 8-bit symbol stream for one lane and assembles each 128b/130b ordered-set block (16 symbols) into one 128-bit word. Emits a one-cycle valid strobe per completed block, so os_checker can consume it directly.
Data blocks are skipped; framing errors are flagged.

Parameters:
SYMS_PER_BLOCK, 16, symbols per block; fixed at 16 for 128b/130b. Width math assumes 16.
CNT_W, 8, width of saturating ordered-set counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
sym_in  input  8  received symbol
sym_valid  input  1  sym_in valid this cycle; low = stall, nothing consumed
block_start  input  1  sym_in is symbol 0 of a new block; ignored unless sym_valid=1
sync_hdr  input  2  block sync header, sampled only with block_start&sym_valid; 2'b01 = ordered set, 2'b10 = data
orderedset  output  128  assembled block; symbol i at bits [8i+7:8i]
valid  output  1  one-cycle pulse; orderedset holds a new complete block
block_err  output  1  one-cycle pulse on framing error
os_count  output  CNT_W  number of valid pulses issued, saturating

Behaviour:
- Reset (async, reset=0): state=IDLE, sym_idx=0, orderedset=0, valid=0, block_err=0, os_count=0. The shift/accumulate buffer is cleared. Reset mid-block discards the partial block with no valid and no block_err.
- States: IDLE, ASSEMBLE, DISCARD. sym_idx is a 4-bit index of the next symbol within the block.
- Only cycles with sym_valid=1 are accepted. On stall cycles, sym_idx, state and buffer hold, and valid/block_err are 0.
- IDLE:
  - block_start with sync_hdr=01: write sym_in to buffer slot 0, sym_idx=1, go to ASSEMBLE.
  - block_start with sync_hdr=10: sym_idx=1, go to DISCARD.
  - block_start with sync_hdr=00 or 11: block_err pulse next cycle, stay in IDLE.
  - Accepted symbol without block_start: ignored silently.
- ASSEMBLE, accepted symbol without block_start:
  - Write sym_in to slot sym_idx and increment sym_idx.
  - If sym_idx was 15: copy the full buffer (including this symbol) to orderedset, pulse valid next cycle, go to IDLE. os_count increments unless already all-ones.
- DISCARD, accepted symbol without block_start: increment sym_idx; at sym_idx=15 go to IDLE. No outputs.
- block_start while in ASSEMBLE or DISCARD with sym_idx≠0 is an early block boundary:
  - Pulse block_err; the partial block is discarded with no valid.
  - The current symbol is processed as a fresh block_start in the same cycle, per the IDLE rules above.
  - If the new sync_hdr is also invalid, only a single block_err pulse is issued.
- Latency: 16th symbol accepted at edge N → valid=1 and new orderedset during cycle N+1. valid is never high two consecutive cycles. Minimum spacing between pulses is 16 accepted symbols.
- orderedset is stable between valid pulses. It changes only on the cycle valid rises.
- Buffer slots not written in the current block retain stale data; they are never exposed, because a valid pulse requires all 16 slots to have been written.

Optional Feature:
Macro OS_SKP_FILTER_EN.
- Defined: a completed block whose symbol 0 is 8'hAA (SKP ordered set) produces no valid, does not update orderedset, and does not increment os_count. The state still returns to IDLE normally.
- Undefined: SKP blocks are delivered like any other ordered set.

Test Plan:
- Reset, then 16 contiguous symbols 8'h00..8'h0F with block_start+sync_hdr=01 on the first → one valid pulse one cycle after the last symbol; orderedset=128'h0F0E…0100; os_count=1.
- TS1 block (sym1=8'h05, sym2=8'hF7, sym10=8'h2A) with sym_valid toggling 1/0 every cycle → single valid after the 16th accepted symbol; orderedset[15:8]=05, [23:16]=F7, [87:80]=2A.
- Data block (sync_hdr=10, 16 symbols), then an OS block → no valid for the data block, exactly one valid for the OS block, no block_err.
- OS block cut after 7 symbols by a new block_start (sync_hdr=01) → block_err pulse, no valid for the partial block; the following 16 symbols produce one valid containing only the new block.
- block_start with sync_hdr=11 → one block_err pulse; the next 15 plain symbols are ignored with no valid; reset asserted mid-ASSEMBLE → all outputs 0 immediately, no valid afterwards.
- With OS_SKP_FILTER_EN defined, an OS block with sym0=8'hAA followed by a TS1 block → exactly one valid (TS1), os_count=1. Without the macro, two valids and os_count=2.
